ttl_quad_gate_sequencer: RTL and testbench

//  Self-test sequencer for the quad 2-input 74-series gate packages (7400 NAND, 7408 AND,
//  7432 OR, 7486 XOR). It drives all four gates of one package through the full 2-input

---
 rtl/ttl_pkg.sv | 32 +++
 rtl/ttl_quad_gate_sequencer.sv | 139 +++++++++++++
 tb/tb_ttl_quad_gate_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ttl_pkg.sv
// Shared definitions for the 74-series quad 2-input gate self-test sequencer.
package ttl_pkg;

    // Gate type codes as presented on gate_type
    typedef enum logic [1:0] {
        TTL_NAND = 2'd0,
        TTL_AND  = 2'd1,
        TTL_OR   = 2'd2,
        TTL_XOR  = 2'd3
    } ttl_type_e;

    // Sequencer state encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } ttl_state_e;

    // Golden 2-input function of one gate of the given package type
    function automatic logic ttl_gate_eval(input logic [1:0] gtype, input logic a, input logic b);
        logic y;
        case (gtype)
            TTL_NAND: y = ~(a & b);
            TTL_AND:  y = a & b;
            TTL_OR:   y = a | b;
            default:  y = a ^ b;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/ttl_quad_gate_sequencer.sv
// Walks one quad 2-input gate package through its full truth table and reports pass/fail.
module ttl_quad_gate_sequencer
    import ttl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned NGATES        = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        gate_type,
    input  logic [NGATES-1:0] dut_y,
    output logic [NGATES-1:0] dut_a,
    output logic [NGATES-1:0] dut_b,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [NGATES-1:0] fail_mask,
    output logic [1:0]        fail_vec
);

    localparam int unsigned CLOG_S = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned CNT_W  = (CLOG_S > 1) ? CLOG_S : 1;
    localparam int unsigned RELOAD_VAL = (SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(RELOAD_VAL);
    // With zero settle time a freshly driven vector is checked on the very next cycle
    localparam ttl_state_e FIRST_ST = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;

    ttl_state_e        state_q, state_d;
    logic [1:0]        vec_q, vec_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        type_q, type_d;
    logic [NGATES-1:0] dut_a_d, dut_b_d, fail_mask_d;
    logic              busy_d, done_d, pass_d;
    logic [1:0]        fail_vec_d;
    logic              exp_bit;
    logic [NGATES-1:0] mm;
    logic [1:0]        vec_nx;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            vec_q     <= 2'd0;
            cnt_q     <= '0;
            type_q    <= 2'd0;
            dut_a     <= '0;
            dut_b     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= '0;
            fail_vec  <= 2'd0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            cnt_q     <= cnt_d;
            type_q    <= type_d;
            dut_a     <= dut_a_d;
            dut_b     <= dut_b_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
            fail_mask <= fail_mask_d;
            fail_vec  <= fail_vec_d;
        end
    end

    // Next-state, vector drive and result accumulation
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        cnt_d       = cnt_q;
        type_d      = type_q;
        dut_a_d     = dut_a;
        dut_b_d     = dut_b;
        done_d      = 1'b0;
        pass_d      = pass;
        fail_mask_d = fail_mask;
        fail_vec_d  = fail_vec;
        vec_nx      = vec_q + 2'd1;

        // X/Z on a gate output is a mismatch, hence the case inequality
        exp_bit = ttl_gate_eval(type_q, vec_q[1], vec_q[0]);
        mm      = '0;
        for (int i = 0; i < int'(NGATES); i++) begin
            mm[i] = (dut_y[i] !== exp_bit);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    type_d      = gate_type;
                    fail_mask_d = '0;
                    fail_vec_d  = 2'd0;
                    pass_d      = 1'b0;
                    vec_d       = 2'd0;
                    dut_a_d     = '0;
                    dut_b_d     = '0;
                    cnt_d       = RELOAD;
                    state_d     = FIRST_ST;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_CHECK: begin
                fail_mask_d = fail_mask | mm;
                // fail_mask is cleared at start, so empty means no earlier failure this run
                if ((mm != '0) && (fail_mask == '0)) begin
                    fail_vec_d = vec_q;
                end
                if (vec_q != 2'd3) begin
                    vec_d   = vec_nx;
                    dut_a_d = {NGATES{vec_nx[1]}};
                    dut_b_d = {NGATES{vec_nx[0]}};
                    cnt_d   = RELOAD;
                    state_d = FIRST_ST;
                end else begin
                    dut_a_d = '0;
                    dut_b_d = '0;
                    done_d  = 1'b1;
                    pass_d  = (fail_mask_d == '0);
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
    end

endmodule

// File: tb/tb_ttl_quad_gate_sequencer.sv
// Directed bench for the quad gate sequencer with a results scoreboard and two settle settings.
module tb_ttl_quad_gate_sequencer;
    import ttl_pkg::*;

    typedef struct packed {
        logic       pass;
        logic [3:0] mask;
        logic [1:0] fvec;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start2, start0, xbit;
    logic [1:0] gate_type;
    logic [1:0] mt2, fl2, mt0, fl0;
    logic [3:0] y2, y0, a2, b2, a0, b0, fm2, fm0;
    logic       busy2, done2, pass2, busy0, done0, pass0;
    logic [1:0] fv2, fv0;

    int   tests  = 0;
    int   failed = 0;
    exp_t sb[$];

    ttl_quad_gate_sequencer #(.SETTLE_CYCLES(2), .NGATES(4)) dut_s2 (
        .clk(clk), .rst(rst), .start(start2), .gate_type(gate_type), .dut_y(y2),
        .dut_a(a2), .dut_b(b2), .busy(busy2), .done(done2), .pass(pass2),
        .fail_mask(fm2), .fail_vec(fv2)
    );

    ttl_quad_gate_sequencer #(.SETTLE_CYCLES(0), .NGATES(4)) dut_s0 (
        .clk(clk), .rst(rst), .start(start0), .gate_type(gate_type), .dut_y(y0),
        .dut_a(a0), .dut_b(b0), .busy(busy0), .done(done0), .pass(pass0),
        .fail_mask(fm0), .fail_vec(fv0)
    );

    // Package under test: fl 0=correct mt, 1=wired as OR, 2=gate 2 stuck-at-1, 3=gate 0 driven by xbit
    function automatic logic [3:0] model_y(input logic [1:0] mt, input logic [1:0] fl,
                                           input logic a, input logic b, input logic xb);
        logic [3:0] y;
        y = {4{ttl_gate_eval(mt, a, b)}};
        case (fl)
            2'd1:    y = {4{a | b}};
            2'd2:    y[2] = 1'b1;
            2'd3:    y[0] = xb;
            default: ;
        endcase
        return y;
    endfunction

    always_comb y2 = model_y(mt2, fl2, a2[0], b2[0], xbit);
    always_comb y0 = model_y(mt0, fl0, a0[0], b0[0], xbit);

    // Expected run summary: walk the truth table against the faulty package
    function automatic exp_t exp_result(input logic [1:0] typ, input logic [1:0] mt,
                                        input logic [1:0] fl, input logic xb);
        exp_t       e;
        logic [3:0] y, mmv;
        logic [1:0] vv;
        e = '0;
        for (int v = 0; v < 4; v++) begin
            vv = 2'(v);
            y  = model_y(mt, fl, vv[1], vv[0], xb);
            for (int g = 0; g < 4; g++) mmv[g] = (y[g] !== ttl_gate_eval(typ, vv[1], vv[0]));
            if ((mmv != 4'h0) && (e.mask == 4'h0)) e.fvec = vv;
            e.mask = e.mask | mmv;
        end
        e.pass = (e.mask == 4'h0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full run from an IDLE negedge; sel=1 picks the zero-settle instance
    task automatic run(input bit sel, input logic [1:0] typ, input logic [1:0] mt,
                       input logic [1:0] fl, input bit disturb);
        int         s, dc;
        exp_t       e;
        logic [1:0] v;
        logic [3:0] oa, ob, ofm;
        logic       obusy, odone, opass;
        logic [1:0] ofv;
        s  = sel ? 0 : 2;
        dc = 4 * (s + 1) + 1;
        if (sel) begin mt0 = mt; fl0 = fl; end
        else     begin mt2 = mt; fl2 = fl; end
        gate_type = typ;
        sb.push_back(exp_result(typ, mt, fl, xbit));
        if (sel) start0 = 1'b1; else start2 = 1'b1;
        for (int c = 1; c <= dc + 1; c++) begin
            @(negedge clk);
            if (c == 1) begin start0 = 1'b0; start2 = 1'b0; end
            if (disturb && c == 4) begin start2 = 1'b1; gate_type = 2'd2; end
            if (disturb && c == 5) start2 = 1'b0;
            oa    = sel ? a0 : a2;       ob    = sel ? b0 : b2;
            obusy = sel ? busy0 : busy2; odone = sel ? done0 : done2;
            opass = sel ? pass0 : pass2; ofm   = sel ? fm0 : fm2;
            ofv   = sel ? fv0 : fv2;
            for (int i = 0; i < 4; i++) begin
                if (c == (i + 1) * (s + 1)) begin
                    v = 2'(i);
                    check($sformatf("vec%0d_a c%0d", i, c), 32'(oa), 32'({4{v[1]}}));
                    check($sformatf("vec%0d_b c%0d", i, c), 32'(ob), 32'({4{v[0]}}));
                    check($sformatf("busy c%0d", c), 32'(obusy), 32'd1);
                end
            end
            if (c == dc) begin
                check("done_pulse", 32'(odone), 32'd1);
                check("busy_in_done", 32'(obusy), 32'd0);
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("pass", 32'(opass), 32'(e.pass));
                    check("fail_mask", 32'(ofm), 32'(e.mask));
                    check("fail_vec", 32'(ofv), 32'(e.fvec));
                end
            end else begin
                check($sformatf("no_done c%0d", c), 32'(odone), 32'd0);
            end
        end
        gate_type = typ;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start2 = 1'b0; start0 = 1'b0; gate_type = 2'd0;
        mt2 = 2'd0; fl2 = 2'd0; mt0 = 2'd0; fl0 = 2'd0; xbit = 1'bx;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy2), 32'd0);
        check("rst_done", 32'(done2), 32'd0);
        check("rst_pass", 32'(pass2), 32'd0);
        check("rst_a", 32'(a2), 32'd0);
        check("rst_b", 32'(b2), 32'd0);
        check("rst_mask", 32'(fm2), 32'd0);
        check("rst_fvec", 32'(fv2), 32'd0);
        check("rst_busy_s0", 32'(busy0), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Correct NAND package
        run(1'b0, TTL_NAND, TTL_NAND, 2'd0, 1'b0);
        check("t1_pass_const", 32'(pass2), 32'd1);

        // XOR selected, package wired as OR: only vector 3 differs
        run(1'b0, TTL_XOR, TTL_NAND, 2'd1, 1'b0);
        check("t2_mask_const", 32'(fm2), 32'hF);
        check("t2_fvec_const", 32'(fv2), 32'd3);
        check("t2_pass_const", 32'(pass2), 32'd0);

        // AND with gate 2 stuck-at-1: vectors 0..2 differ
        run(1'b0, TTL_AND, TTL_AND, 2'd2, 1'b0);
        check("t3_mask_const", 32'(fm2), 32'h4);
        check("t3_fvec_const", 32'(fv2), 32'd0);
        check("t3_pass_const", 32'(pass2), 32'd0);
        repeat (3) @(negedge clk);
        check("t3_hold_mask", 32'(fm2), 32'h4);
        check("t3_hold_pass", 32'(pass2), 32'd0);
        check("t3_idle_busy", 32'(busy2), 32'd0);

        // Start and gate_type disturbed mid-run: judged as NAND, single done
        run(1'b0, TTL_NAND, TTL_NAND, 2'd0, 1'b1);
        check("t4_pass_const", 32'(pass2), 32'd1);

        // Reset in cycle 6 of a failing run
        mt2 = TTL_AND; fl2 = 2'd2; gate_type = TTL_AND; start2 = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) start2 = 1'b0;
            if (c == 4) check("t5_mask_mid", 32'(fm2), 32'h4);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy", 32'(busy2), 32'd0);
        check("t5_a", 32'(a2), 32'd0);
        check("t5_b", 32'(b2), 32'd0);
        check("t5_mask", 32'(fm2), 32'd0);
        check("t5_done", 32'(done2), 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("t5_no_done %0d", c), 32'(done2), 32'd0);
        end
        run(1'b0, TTL_AND, TTL_AND, 2'd0, 1'b0);
        check("t5_pass_const", 32'(pass2), 32'd1);

        // Zero settle time, OR package: correct, then gate 0 driven unknown
        run(1'b1, TTL_OR, TTL_OR, 2'd0, 1'b0);
        check("t6_pass_const", 32'(pass0), 32'd1);
        run(1'b1, TTL_OR, TTL_OR, 2'd3, 1'b0);
        check("t6_pass_x", 32'(pass0), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
